sram_bus_ctrl: RTL and testbench
================================

SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning bus address width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of implemented words (DEPTH_LOG2 <= ADDR_W).
REQ-004 The block SHALL have parameter WAIT_STATES, default 1, range 0..15, meaning extra cycles inserted before each access.
REQ-005 The block SHALL have port Clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port Addr, input, ADDR_W, word address.
REQ-008 The block SHALL have port RD, input, 1, read request strobe.
REQ-009 The block SHALL have port WR, input, 1, write request strobe.
REQ-010 The block SHALL have port DataIn, input, DATA_W, write data.
REQ-011 The block SHALL have port DataOut, output, DATA_W, registered read data.
REQ-012 The block SHALL have port Ready, output, 1, one-cycle completion pulse.
REQ-013 The block SHALL have port Busy, output, 1, high whenever the state is not IDLE.
REQ-014 The block SHALL have port Err, output, 1, error flag, valid only while Ready=1.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, ACC and RESP.
REQ-016 In IDLE, a rising edge with RD or WR high SHALL accept the request, latching Addr, DataIn and the request type.
REQ-017 On accept, the FSM SHALL go to WAIT if WAIT_STATES>0, else to ACC.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to ACC.
REQ-019 ACC SHALL last one cycle: a write stores the latched data, a read loads DataOut; the FSM then goes to RESP.
REQ-020 RESP SHALL last one cycle with Ready=1, then return to IDLE; Ready SHALL be 0 in every other state.
REQ-021 Ready SHALL be high in the cycle following accept edge + WAIT_STATES + 1 edges: 2 cycles after accept for WAIT_STATES=0, 3 cycles for WAIT_STATES=1.
REQ-022 RD and WR sampled while Busy=1 SHALL be ignored; no queueing.
REQ-023 RD and WR both high at accept SHALL give Err=1 in RESP, with no memory or DataOut change.
REQ-024 A latched address with any bit at or above DEPTH_LOG2 set SHALL give Err=1 in RESP, with no memory or DataOut change.
REQ-025 DataOut SHALL hold its value until the next successful read; writes and errors SHALL leave it unchanged.
REQ-026 A write followed by a read to the same address SHALL return the written data; there is no read-before-write hazard because accesses are serialised.

Reset
REQ-027 Reset_n low SHALL immediately force state IDLE, DataOut=0, Ready=0, Err=0, Busy=0 and the wait counter to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation; a write aborted before ACC SHALL NOT modify memory.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 Reset deassertion SHALL be synchronised by the integrator; after deassertion the first request SHALL be accepted on the first rising edge.

Configuration
REQ-031 With macro SRAM_BUS_CTRL_PARITY_EN defined, each word SHALL store one extra even-parity bit computed on write.
REQ-032 With SRAM_BUS_CTRL_PARITY_EN defined, a read whose stored parity mismatches SHALL set Err=1 in RESP and still update DataOut.
REQ-033 Without SRAM_BUS_CTRL_PARITY_EN, there SHALL be no parity storage, and Err SHALL be driven only by REQ-023 and REQ-024.

Verification
REQ-034 Bench SHALL cover: WAIT_STATES=1, WR Addr=0x0005 DataIn=0xBEEF, then RD Addr=0x0005 -> each Ready 3 cycles after accept, DataOut=0xBEEF, Err=0.
REQ-035 Bench SHALL cover: WAIT_STATES=0, RD Addr=0x0005 -> Ready exactly 2 cycles after accept, Busy high for 2 cycles.
REQ-036 Bench SHALL cover: RD=WR=1 at Addr=0x0001 -> Ready=1 with Err=1, DataOut unchanged, word 1 unchanged.
REQ-037 Bench SHALL cover: DEPTH_LOG2=10, RD Addr=0x0400 -> Err=1, DataOut unchanged.
REQ-038 Bench SHALL cover: new RD while Busy=1 -> ignored, exactly one Ready pulse.
REQ-039 Bench SHALL cover: WR 0x1234 to Addr=0x0002, Reset_n pulsed low during WAIT -> outputs 0 immediately; a later read of Addr=0x0002 returns its prior value.

Source files
------------

// File: rtl/sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_ctrl
//  Description : Single-port SRAM bus controller. One request is accepted at a
//                time, optionally delayed by WAIT_STATES cycles, then performed
//                in a single access cycle and acknowledged with a Ready pulse.
//                Conflicting strobes and out-of-range addresses report Err.
//                Optional feature macro: SRAM_BUS_CTRL_PARITY_EN adds one
//                even-parity bit per stored word, checked on reads.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bus_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              RD,
    input  logic              WR,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Ready,
    output logic              Busy,
    output logic              Err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef SRAM_BUS_CTRL_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rd_q;
    logic                wr_q;
    logic [DATA_W-1:0]   dout_q;
    logic                err_q;

    logic [MEM_W-1:0]    mem_q [DEPTH];

    logic                accept;
    logic                range_err;
    logic                req_err;
    logic                parity_err;
    logic                mem_we;
    logic                dout_load;
    logic [MEM_W-1:0]    rd_word;
    logic [MEM_W-1:0]    wr_word;

    // Access-stage decode: error classification, memory write and read data.
    always_comb begin
        range_err = (addr_q >> DEPTH_LOG2) != '0;
        req_err   = (rd_q && wr_q) || range_err;
        rd_word   = mem_q[addr_q[DEPTH_LOG2-1:0]];
`ifdef SRAM_BUS_CTRL_PARITY_EN
        wr_word    = {^wdata_q, wdata_q};
        parity_err = rd_q && !req_err && (^rd_word);
`else
        wr_word    = wdata_q;
        parity_err = 1'b0;
`endif
        mem_we    = (state_q == S_ACC) && wr_q && !req_err;
        dout_load = (state_q == S_ACC) && rd_q && !req_err;
    end

    // Next-state logic for the request sequencer and its wait-state counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (RD || WR) begin
                    accept = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, request latches, read data and error flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= Addr;
                wdata_q <= DataIn;
                rd_q    <= RD;
                wr_q    <= WR;
            end
            if (state_q == S_ACC) begin
                err_q <= req_err || parity_err;
            end
            if (dout_load) begin
                dout_q <= rd_word[DATA_W-1:0];
            end
        end
    end

    // Storage array; intentionally not reset so contents survive Reset_n.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[addr_q[DEPTH_LOG2-1:0]] <= wr_word;
        end
    end

    assign DataOut = dout_q;
    assign Ready   = (state_q == S_RESP);
    assign Busy    = (state_q != S_IDLE);
    assign Err     = (state_q == S_RESP) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_ctrl
//  Description : Directed bench for sram_bus_ctrl. Instance 1 uses one wait
//                state, instance 0 uses none; both share clock and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_bus_ctrl;

    logic              Clk;
    logic              Reset_n;
    logic [1:0]        rd_s;
    logic [1:0]        wr_s;
    logic [1:0][15:0]  addr_s;
    logic [1:0][15:0]  din_s;
    logic [1:0][15:0]  dout_s;
    logic [1:0]        ready_s;
    logic [1:0]        busy_s;
    logic [1:0]        err_s;

    int checks = 0;
    int errors = 0;

    sram_bus_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0)
    ) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .Addr(addr_s[0]), .RD(rd_s[0]),
        .WR(wr_s[0]), .DataIn(din_s[0]), .DataOut(dout_s[0]),
        .Ready(ready_s[0]), .Busy(busy_s[0]), .Err(err_s[0])
    );

    sram_bus_ctrl #(
        .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .WAIT_STATES(1)
    ) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .Addr(addr_s[1]), .RD(rd_s[1]),
        .WR(wr_s[1]), .DataIn(din_s[1]), .DataOut(dout_s[1]),
        .Ready(ready_s[1]), .Busy(busy_s[1]), .Err(err_s[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One bus transaction. Expected Ready edge count after the accept edge is
    // WAIT_STATES+1 (2 for instance 1, 1 for instance 0); Busy stays high for
    // that many samples plus the Ready sample.
    task automatic req(input int sel, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d,
                       input logic exp_err, input string tag);
        int n;
        int bc;
        int exp_lat;
        exp_lat   = (sel == 1) ? 2 : 1;
        rd_s[sel]   = r;
        wr_s[sel]   = w;
        addr_s[sel] = a;
        din_s[sel]  = d;
        tick();
        rd_s[sel] = 1'b0;
        wr_s[sel] = 1'b0;
        n  = 0;
        bc = 0;
        while (!ready_s[sel] && n < 20) begin
            if (busy_s[sel]) bc++;
            tick();
            n++;
        end
        if (busy_s[sel]) bc++;
        check({tag, ".latency"}, 32'(n), 32'(exp_lat));
        check({tag, ".busy_cycles"}, 32'(bc), 32'(exp_lat + 1));
        check({tag, ".err"}, {31'd0, err_s[sel]}, {31'd0, exp_err});
        tick();
        check({tag, ".ready_pulse_end"}, {31'd0, ready_s[sel]}, 32'd0);
        check({tag, ".idle_after"}, {31'd0, busy_s[sel]}, 32'd0);
    endtask

    initial begin
        int pulses;
        Reset_n = 1'b0;
        rd_s    = '0;
        wr_s    = '0;
        addr_s  = '0;
        din_s   = '0;
        #1;
        check("reset.dout", {16'd0, dout_s[1]}, 32'd0);
        check("reset.ready", {31'd0, ready_s[1]}, 32'd0);
        check("reset.err", {31'd0, err_s[1]}, 32'd0);
        check("reset.busy", {31'd0, busy_s[1]}, 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;

        // One wait state: write then read back the same word.
        req(1, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, "ws1_wr5");
        req(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, "ws1_rd5");
        check("ws1_rd5.data", {16'd0, dout_s[1]}, 32'h0000BEEF);

        // Zero wait states.
        req(0, 1'b0, 1'b1, 16'h0005, 16'hCAFE, 1'b0, "ws0_wr5");
        req(0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, "ws0_rd5");
        check("ws0_rd5.data", {16'd0, dout_s[0]}, 32'h0000CAFE);

        // Conflicting strobes must not touch memory or DataOut.
        req(1, 1'b0, 1'b1, 16'h0001, 16'h1111, 1'b0, "wr1");
        req(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, "rd5_again");
        req(1, 1'b1, 1'b1, 16'h0001, 16'hDEAD, 1'b1, "both");
        check("both.dout_kept", {16'd0, dout_s[1]}, 32'h0000BEEF);
        req(1, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, "rd1");
        check("rd1.word_unchanged", {16'd0, dout_s[1]}, 32'h00001111);

        // Address range boundary.
        req(1, 1'b1, 1'b0, 16'h0400, 16'h0000, 1'b1, "rd400");
        check("rd400.dout_kept", {16'd0, dout_s[1]}, 32'h00001111);
        req(1, 1'b0, 1'b1, 16'h8005, 16'h7777, 1'b1, "wr8005");
        req(1, 1'b0, 1'b1, 16'h03FF, 16'hA5A5, 1'b0, "wr3ff");
        req(1, 1'b1, 1'b0, 16'h03FF, 16'h0000, 1'b0, "rd3ff");
        check("rd3ff.data", {16'd0, dout_s[1]}, 32'h0000A5A5);
        req(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, "rd5_noalias");
        check("rd5_noalias.data", {16'd0, dout_s[1]}, 32'h0000BEEF);

        // Request raised while busy is dropped: one Ready, data from addr 5.
        req(1, 1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, "wr3");
        rd_s[1]   = 1'b1;
        addr_s[1] = 16'h0005;
        tick();
        addr_s[1] = 16'h0003;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready_s[1]) pulses++;
            if (i == 1) rd_s[1] = 1'b0;
            tick();
        end
        check("busy_ignore.pulses", 32'(pulses), 32'd1);
        check("busy_ignore.data", {16'd0, dout_s[1]}, 32'h0000BEEF);

        // Reset during WAIT aborts a write.
        req(1, 1'b0, 1'b1, 16'h0002, 16'h5555, 1'b0, "wr2_prior");
        wr_s[1]   = 1'b1;
        addr_s[1] = 16'h0002;
        din_s[1]  = 16'h1234;
        tick();
        wr_s[1] = 1'b0;
        check("abort.in_wait_busy", {31'd0, busy_s[1]}, 32'd1);
        Reset_n = 1'b0;
        #1;
        check("abort.dout", {16'd0, dout_s[1]}, 32'd0);
        check("abort.ready", {31'd0, ready_s[1]}, 32'd0);
        check("abort.busy", {31'd0, busy_s[1]}, 32'd0);
        check("abort.err", {31'd0, err_s[1]}, 32'd0);
        tick();
        tick();
        Reset_n = 1'b1;
        req(1, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, "rd2_after_reset");
        check("rd2_after_reset.data", {16'd0, dout_s[1]}, 32'h00005555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
